registro_mem_wb_hs: RTL

- Parametrised next-generation MEM/WB pipeline register for the vector processor, between the memory stage and the write-back mux / register files.
- Adds a valid/ready handshake with a 1-entry skid buffer, a synchronous flush, and write-enable masking for bubbles.
- Keeps the two-phase timing (posedge capture, negedge presentation) as a selectable mode.

---
 rtl/vp_pipe_pkg.sv | 24 ++
 rtl/pipe_skid_reg.sv | 70 +++++++
 rtl/registro_mem_wb_hs.sv | 113 +++++++++++
 3 files changed

// File: rtl/vp_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vp_pipe_pkg
// Description : Shared widths and write-back control bundle for the vector
//               processor pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package vp_pipe_pkg;

  localparam int VP_DATA_W  = 32;
  localparam int VP_ADDR_W  = 3;
  localparam int VP_SDATA_W = 8;

  // Write-back control bundle carried from ID/EX down to MEM/WB
  typedef struct packed {
    logic sel_wb;
    logic reg_wrv;
    logic reg_wrs;
  } wb_ctrl_t;

  localparam int WB_CTRL_W = $bits(wb_ctrl_t);

endpackage : vp_pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Generic valid/ready pipeline register with a main (presented)
//               entry and a 1-entry skid buffer, plus synchronous flush.
//               in_ready depends only on registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_valid;
  logic [W-1:0] r_main_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;

  logic w_accept;
  logic w_release;

  // Skid occupancy alone decides readiness, so out_ready never reaches in_ready
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_release = r_main_valid & out_ready;

  // Main/skid entry update; flush wins over any accept or release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
      end
    end else if (w_release) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_data  <= in_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

endmodule : pipe_skid_reg
`default_nettype wire

// File: rtl/registro_mem_wb_hs.sv
`default_nettype none
// ============================================================================
// Module      : registro_mem_wb_hs
// Description : MEM/WB pipeline register with valid/ready handshake, skid
//               buffer, flush, write-enable masking for bubbles and optional
//               negedge presentation of the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module registro_mem_wb_hs
  import vp_pipe_pkg::*;
#(
  parameter int DATA_W  = VP_DATA_W,
  parameter int ADDR_W  = VP_ADDR_W,
  parameter int SDATA_W = VP_SDATA_W,
  parameter bit NEG_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sel_wb_in,
  input  logic               reg_wrv_in,
  input  logic               reg_wrs_in,
  input  logic [DATA_W-1:0]  mem_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [ADDR_W-1:0]  dir_dest_in,
  input  logic [SDATA_W-1:0] data_wrs_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_wb_out,
  output logic               reg_wrv_out,
  output logic               reg_wrs_out,
  output logic [DATA_W-1:0]  mem_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [ADDR_W-1:0]  dir_dest_out,
  output logic [SDATA_W-1:0] data_wrs_out
);

  typedef struct packed {
    wb_ctrl_t           ctrl;
    logic [DATA_W-1:0]  mem;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  dir;
    logic [SDATA_W-1:0] wrs_data;
  } payload_t;

  localparam int PAY_W = $bits(payload_t);

  payload_t w_in_pay;
  payload_t w_main_pay;
  payload_t w_pres_pay;
  logic     w_main_valid;
  logic     w_pres_valid;

  assign w_in_pay.ctrl.sel_wb  = sel_wb_in;
  assign w_in_pay.ctrl.reg_wrv = reg_wrv_in;
  assign w_in_pay.ctrl.reg_wrs = reg_wrs_in;
  assign w_in_pay.mem          = mem_in;
  assign w_in_pay.data         = data_in;
  assign w_in_pay.dir          = dir_dest_in;
  assign w_in_pay.wrs_data     = data_wrs_in;

  pipe_skid_reg #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pay),
    .out_valid (w_main_valid),
    .out_ready (out_ready),
    .out_data  (w_main_pay)
  );

  generate
    if (NEG_OUT) begin : g_neg_out
      logic     r_pres_valid;
      payload_t r_pres_pay;

      // Re-present main on the falling edge so write-back sees it half a cycle after capture
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pres_valid <= 1'b0;
          r_pres_pay   <= '0;
        end else begin
          r_pres_valid <= w_main_valid;
          r_pres_pay   <= w_main_pay;
        end
      end

      assign w_pres_valid = r_pres_valid;
      assign w_pres_pay   = r_pres_pay;
    end else begin : g_pos_out
      assign w_pres_valid = w_main_valid;
      assign w_pres_pay   = w_main_pay;
    end
  endgenerate

  // Bubbles must never write either register file
  assign out_valid    = w_pres_valid;
  assign sel_wb_out   = w_pres_pay.ctrl.sel_wb;
  assign reg_wrv_out  = w_pres_pay.ctrl.reg_wrv & w_pres_valid;
  assign reg_wrs_out  = w_pres_pay.ctrl.reg_wrs & w_pres_valid;
  assign mem_out      = w_pres_pay.mem;
  assign data_out     = w_pres_pay.data;
  assign dir_dest_out = w_pres_pay.dir;
  assign data_wrs_out = w_pres_pay.wrs_data;

endmodule : registro_mem_wb_hs
`default_nettype wire
